// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared encodings for the pipelined barrel shifter: operation and direction codes,
// plus the fill-bit rule applied when an operand enters the pipe.
package shifter_pkg;

    localparam logic [1:0] OP_LOGIC = 2'd0;
    localparam logic [1:0] OP_ARITH = 2'd1;
    localparam logic [1:0] OP_ROT   = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Only an arithmetic right shift replicates the sign bit; everything else fills with zero.
    function automatic logic fill_bit(input logic msb, input logic dir, input logic [1:0] op);
        logic fill;
        if ((op == OP_ARITH) && (dir == DIR_RIGHT)) begin
            fill = msb;
        end else begin
            fill = 1'b0;
        end
        return fill;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready stream bundle for the barrel shifter: operation in, shifted result out.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic             in_dir;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One registered log2 stage of the barrel shifter: conditionally shifts or rotates by AMT
// and forwards the operation context to the next stage, holding everything on stall.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int AMT   = 1,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             en,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             dir_i,
    input  logic [1:0]       op_i,
    input  logic             fill_i,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic [SHW-1:0]   shamt_q,
    output logic             dir_q,
    output logic [1:0]       op_q,
    output logic             fill_q,
    output logic             zero_q
);

    logic [WIDTH-1:0] shifted_s;
    logic             valid_d;
    logic [WIDTH-1:0] data_d;
    logic [SHW-1:0]   shamt_d;
    logic             dir_d;
    logic [1:0]       op_d;
    logic             fill_d;
    logic             zero_d;

    // Shift-by-AMT mux; the reserved op falls into the logical path via default
    always_comb begin
        shifted_s = data_i;
        if (en) begin
            case (op_i)
                OP_ROT: begin
                    if (dir_i == DIR_LEFT) begin
                        shifted_s = {data_i[WIDTH-AMT-1:0], data_i[WIDTH-1:WIDTH-AMT]};
                    end else begin
                        shifted_s = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
                    end
                end
                default: begin
                    if (dir_i == DIR_LEFT) begin
                        shifted_s = {data_i[WIDTH-AMT-1:0], {AMT{fill_i}}};
                    end else begin
                        shifted_s = {{AMT{fill_i}}, data_i[WIDTH-1:AMT]};
                    end
                end
            endcase
        end else begin
            shifted_s = data_i;
        end
    end

    // Next-state: hold on stall, otherwise load the upstream stage
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        dir_d   = dir_q;
        op_d    = op_q;
        fill_d  = fill_q;
        zero_d  = zero_q;
        if (!stall) begin
            valid_d = valid_i;
            data_d  = shifted_s;
            shamt_d = shamt_i;
            dir_d   = dir_i;
            op_d    = op_i;
            fill_d  = fill_i;
            zero_d  = LAST ? (shifted_s == {WIDTH{1'b0}}) : 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            shamt_q <= {SHW{1'b0}};
            dir_q   <= 1'b0;
            op_q    <= 2'd0;
            fill_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            dir_q   <= dir_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined WIDTH-bit barrel shifter: an input register followed by SHW registered
// power-of-two shift stages, with a single global stall driven by output back-pressure.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_barrel_shifter_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    logic stall_s;

    logic             in_valid_d, in_valid_q;
    logic [WIDTH-1:0] in_data_d,  in_data_q;
    logic [SHW-1:0]   in_shamt_d, in_shamt_q;
    logic             in_dir_d,   in_dir_q;
    logic [1:0]       in_op_d,    in_op_q;
    logic             in_fill_d,  in_fill_q;

    // Index 0 is the input register, index k+1 is the output of stage k
    logic             valid_s [SHW+1];
    logic [WIDTH-1:0] data_s  [SHW+1];
    logic [SHW-1:0]   shamt_s [SHW+1];
    logic             dir_s   [SHW+1];
    logic [1:0]       op_s    [SHW+1];
    logic             fill_s  [SHW+1];
    logic             zero_s  [SHW];

    assign stall_s      = valid_s[SHW] && !bus.out_ready;
    assign bus.in_ready = !stall_s;

    // Input capture: the fill bit is resolved here so later stages never look at the MSB
    always_comb begin
        in_valid_d = in_valid_q;
        in_data_d  = in_data_q;
        in_shamt_d = in_shamt_q;
        in_dir_d   = in_dir_q;
        in_op_d    = in_op_q;
        in_fill_d  = in_fill_q;
        if (!stall_s) begin
            in_valid_d = bus.in_valid;
            in_data_d  = bus.in_data;
            in_shamt_d = bus.in_shamt;
            in_dir_d   = bus.in_dir;
            in_op_d    = bus.in_op;
            in_fill_d  = fill_bit(bus.in_data[WIDTH-1], bus.in_dir, bus.in_op);
        end else begin
            in_valid_d = in_valid_q;
        end
    end

    // Input register
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_data_q  <= {WIDTH{1'b0}};
            in_shamt_q <= {SHW{1'b0}};
            in_dir_q   <= 1'b0;
            in_op_q    <= 2'd0;
            in_fill_q  <= 1'b0;
        end else begin
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
            in_shamt_q <= in_shamt_d;
            in_dir_q   <= in_dir_d;
            in_op_q    <= in_op_d;
            in_fill_q  <= in_fill_d;
        end
    end

    assign valid_s[0] = in_valid_q;
    assign data_s[0]  = in_data_q;
    assign shamt_s[0] = in_shamt_q;
    assign dir_s[0]   = in_dir_q;
    assign op_s[0]    = in_op_q;
    assign fill_s[0]  = in_fill_q;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .AMT   (32'd1 << k),
            .LAST  (k == (SHW - 1))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .stall   (stall_s),
            .en      (shamt_s[k][k]),
            .valid_i (valid_s[k]),
            .data_i  (data_s[k]),
            .shamt_i (shamt_s[k]),
            .dir_i   (dir_s[k]),
            .op_i    (op_s[k]),
            .fill_i  (fill_s[k]),
            .valid_q (valid_s[k+1]),
            .data_q  (data_s[k+1]),
            .shamt_q (shamt_s[k+1]),
            .dir_q   (dir_s[k+1]),
            .op_q    (op_s[k+1]),
            .fill_q  (fill_s[k+1]),
            .zero_q  (zero_s[k])
        );
    end

    assign bus.out_valid = valid_s[SHW];
    assign bus.out_data  = data_s[SHW];
    assign bus.out_zero  = zero_s[SHW-1];

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, fully pipelined barrel shifter with a valid/ready stream interface, generalising the 8-bit combinational shifter. Supports logical, arithmetic and rotate modes in both directions, and adds a zero flag. Each log2 shift stage is registered, so it sits directly in datapaths where a WIDTH-bit combinational shifter would fail timing. It accepts one operation per cycle and stalls under back-pressure.

## Interface
- WIDTH, 32, data width; power of two, >= 2
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  input operation valid
- in_ready  output  1  block can accept input this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHW  shift amount, 0..WIDTH-1
- in_dir  input  1  0 = right, 1 = left
- in_op  input  2  0 = logical, 1 = arithmetic, 2 = rotate, 3 = reserved (treated as logical)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data == 0

## Operation
- SHW stages. Stage k (k = 0..SHW-1, LSB first) shifts by 2^k when shamt bit k is set, otherwise passes through.
- The input register captures data, shamt, dir, op and the fill bit:
  - fill = in_data[WIDTH-1] for arithmetic right shifts.
  - fill = 0 for every other mode.
- Each stage register carries the remaining shamt bits, dir, op, fill and its own valid bit down the pipe.
- Logical and arithmetic shifts fill vacated positions with the fill bit. Arithmetic left is identical to logical left.
- Rotate: bits leaving one end enter the other; no fill.
- shamt = 0 yields out_data = in_data in all modes.
- out_zero is registered alongside out_data. It is computed from the final stage's combinational result.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data and out_zero are held stable while out_valid && !out_ready.
- Stall is global: stall = out_valid && !out_ready.
  - On stall, every stage register holds its value and in_ready = 0.
  - No bubble collapsing; in_ready = !stall.
- A cycle without an input transfer inserts a bubble (valid = 0) into stage 0.

## Timing
- Latency: an item accepted at edge t presents out_valid at edge t+SHW+1. That is one input register plus SHW stage registers, with no stall.
- Throughput: one item per cycle while out_ready = 1. Results emerge in order.
- Reset, applied at any time including mid-operation:
  - All valid bits clear, so in-flight items are discarded.
  - out_valid = 0, out_data = 0, out_zero = 0.
  - in_ready = 1 from the first cycle after rst deasserts; in_ready = 1 while rst is high is don't-care.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path exists.
- A simultaneous output drain and input accept in the same cycle is legal and must not lose or duplicate an item.

## Structure
- Package shifter_pkg holds:
  - The in_op encoding constants: OP_LOGIC, OP_ARITH, OP_ROT, OP_RSVD.
  - The direction constants DIR_RIGHT and DIR_LEFT.
- Sub-module shift_stage, parameters WIDTH and AMT:
  - Contains one combinational shift-by-AMT mux plus its pipeline register, honouring the enable and stall inputs.
  - The top instantiates it SHW times in a generate loop, with AMT = 2^k.

## Test plan
- WIDTH=8, in_data=0xB4, shamt=3, right, arithmetic -> out_data=0xF6, out_zero=0, out_valid exactly SHW+1 = 4 cycles after accept.
- WIDTH=8, 0xB4, shamt=3, left, rotate -> 0xA5. Same operand, right rotate by 3 -> 0x96. Logical left by 2 on 0x81 -> 0x04.
- WIDTH=8, 0x80, shamt=7, logical right -> 0x01. Same operand, logical left by 1 -> 0x00 with out_zero=1. shamt=0 in every mode -> unchanged.
- Stream 16 back-to-back random ops with out_ready=1 -> one result per cycle, in order, matching the reference model.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, out_data stable, no item lost or duplicated after release.
- Assert rst for 1 cycle with 3 items in flight -> out_valid=0 the next cycle, no stale item ever appears, and a new item completes with normal latency.
